// File: rtl/mailbox_pkg.sv
// -----------------------------------------------------------------------------
// mailbox_pkg
// Shared definitions for the MMIO result mailbox:
//   - register offsets (DataAdr[3:2]) of the 16-byte window
//   - STATUS register bit positions
//   - control FSM state type
//   - saturating increment helper for the 16-bit drop counter
// -----------------------------------------------------------------------------
package mailbox_pkg;

    localparam logic [1:0] OFF_MAILBOX = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DONE    = 2'd2;
    localparam logic [1:0] OFF_DROPS   = 2'd3;

    localparam int STAT_DONE  = 0;
    localparam int STAT_PASS  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_FULL  = 3;
    localparam int STAT_OVF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mb_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// -----------------------------------------------------------------------------
// mailbox_fifo
// Synchronous FIFO, WIDTH bits x DEPTH entries (DEPTH power of two, >= 2).
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (pointers and count only)
//   push_i   : write request; accepted when not full, or when full and a
//              pop happens at the same edge
//   pop_i    : read request; ignored while empty
//   wdata_i  : write data
//   rdata_o  : head entry (combinational, meaningful when !empty_o)
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
//   count_o  : number of entries, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module mailbox_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o = (count_q == CW'(0));
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees a slot at the same edge, so a full FIFO can still take a push.
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful behind the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mmio_result_mailbox.sv
// -----------------------------------------------------------------------------
// mmio_result_mailbox
// Memory-mapped result mailbox on the CPU data bus. Program stores to the
// MAILBOX register are queued and streamed out on a valid/ready port; a store
// to DONE latches an end-of-test code and the pass flag.
//
// Register window at BASE_ADDR (offset = DataAdr[3:2]):
//   0x0 MAILBOX  W: push WriteData          R: FIFO count
//   0x4 STATUS   W: ignored                 R: {ovf_sticky, full, empty, pass, done}
//   0x8 DONE     W: latch code (first wins) R: code
//   0xC DROPS    W: clear                   R: 16-bit saturating drop count
//
// Ports:
//   clk, reset (async, active-low), MemWrite, DataAdr, WriteData : CPU side
//   ReadData, hit          : combinational read data / window decode
//   out_valid, out_data, out_ready, out_ts : result stream
//   done, pass             : end-of-test status
//
// Build option: define MAILBOX_TIMESTAMP_EN to tag every queued word with a
// 32-bit free-running cycle count, presented on out_ts; otherwise out_ts = 0.
// -----------------------------------------------------------------------------
module mmio_result_mailbox
    import mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          DEPTH     = 8,
    parameter logic [31:0] PASS_CODE = 32'd7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic [31:0] out_ts,
    output logic        done,
    output logic        pass
);

    localparam int CW = $clog2(DEPTH) + 1;
`ifdef MAILBOX_TIMESTAMP_EN
    localparam int FW = 64;
`else
    localparam int FW = 32;
`endif

    mb_state_t     state_q, state_d;
    logic [31:0]   code_q, code_d;
    logic          pass_q, pass_d;
    logic [15:0]   drops_q, drops_d;
    logic          ovf_q, ovf_d;

    logic [1:0]    off_s;
    logic          wr_s;
    logic          push_req_s;
    logic          pop_req_s;
    logic          drop_s;
    logic [31:0]   status_s;
    logic [FW-1:0] fifo_wdata_s;
    logic [FW-1:0] fifo_rdata_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic          unused_s;

    assign hit      = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign off_s    = DataAdr[3:2];
    assign wr_s     = MemWrite & hit;
    assign unused_s = ^DataAdr[1:0];

    // Once DONE is reached the mailbox is closed to new words but keeps draining.
    assign push_req_s = wr_s & (off_s == OFF_MAILBOX) & (state_q != DONE);
    assign pop_req_s  = out_valid & out_ready;
    assign drop_s     = push_req_s & fifo_full_s & ~pop_req_s;

    assign out_valid = ~fifo_empty_s;
    assign out_data  = fifo_rdata_s[31:0];
    assign done      = (state_q == DONE);
    assign pass      = pass_q;

`ifdef MAILBOX_TIMESTAMP_EN
    logic [31:0] ts_q;

    // Free-running cycle counter used to tag pushed words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= 32'd0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    assign fifo_wdata_s = {ts_q, WriteData};
    assign out_ts       = fifo_rdata_s[63:32];
`else
    assign fifo_wdata_s = WriteData;
    assign out_ts       = 32'd0;
`endif

    mailbox_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push_req_s),
        .pop_i   (pop_req_s),
        .wdata_i (fifo_wdata_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Control FSM: code and pass are captured together with the DONE transition.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, RUN: begin
                if (wr_s && (off_s == OFF_DONE)) begin
                    state_d = DONE;
                    code_d  = WriteData;
                    pass_d  = (WriteData == PASS_CODE);
                end else if (wr_s) begin
                    state_d = RUN;
                end else begin
                    state_d = state_q;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Drop counter and overflow flag; a drop and a clear never coincide since
    // they come from different offsets.
    always_comb begin
        drops_d = drops_q;
        ovf_d   = ovf_q;
        if (drop_s) begin
            drops_d = sat_inc16(drops_q);
            ovf_d   = 1'b1;
        end else if (wr_s && (off_s == OFF_DROPS)) begin
            drops_d = 16'd0;
        end else begin
            drops_d = drops_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            code_q  <= 32'd0;
            pass_q  <= 1'b0;
            drops_q <= 16'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pass_q  <= pass_d;
            drops_q <= drops_d;
            ovf_q   <= ovf_d;
        end
    end

    // STATUS register image.
    always_comb begin
        status_s             = 32'd0;
        status_s[STAT_DONE]  = done;
        status_s[STAT_PASS]  = pass_q;
        status_s[STAT_EMPTY] = fifo_empty_s;
        status_s[STAT_FULL]  = fifo_full_s;
        status_s[STAT_OVF]   = ovf_q;
    end

    // Combinational register read mux; zero outside the window.
    always_comb begin
        ReadData = 32'd0;
        if (hit) begin
            case (off_s)
                OFF_MAILBOX: ReadData = {{(32-CW){1'b0}}, fifo_count_s};
                OFF_STATUS:  ReadData = status_s;
                OFF_DONE:    ReadData = code_q;
                OFF_DROPS:   ReadData = {16'd0, drops_q};
                default:     ReadData = 32'd0;
            endcase
        end else begin
            ReadData = 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_result_mailbox.sv
// -----------------------------------------------------------------------------
// tb_mmio_result_mailbox
// Randomized and directed stimulus against a queue-based reference model of
// the mailbox. Accepted pushes are queued as expected stream words; a separate
// monitor pops and compares whenever the DUT hands a word over.
// -----------------------------------------------------------------------------
module tb_mmio_result_mailbox;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        out_ready = 1'b0;
    logic [31:0] ReadData;
    logic        hit;
    logic        out_valid;
    logic [31:0] out_data;
    logic [31:0] out_ts;
    logic        done;
    logic        pass;

    always #5 clk = ~clk;

    mmio_result_mailbox #(
        .BASE_ADDR (32'h0000_0100),
        .DEPTH     (DEPTH),
        .PASS_CODE (32'd7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .hit       (hit),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_ts    (out_ts),
        .done      (done),
        .pass      (pass)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] exp_q[$];   // {timestamp, data} of words the stream still owes
    int          msize;      // words the mailbox holds
    bit          m_done, m_pass, m_ovf;
    logic [31:0] m_code;
    int          m_drops;
    int          edge_cnt;   // clock edges since reset release

    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] adr);
        logic [31:0] r;
        r = 32'd0;
        if (adr[31:4] == 28'h0000010) begin
            case (adr[3:2])
                2'd0: r = 32'(msize);
                2'd1: r = {27'd0, m_ovf, (msize == DEPTH), (msize == 0), m_pass, m_done};
                2'd2: r = m_code;
                default: r = 32'(m_drops);
            endcase
        end
        return r;
    endfunction

    task automatic model_clear();
        msize = 0; m_done = 0; m_pass = 0; m_ovf = 0; m_code = 32'd0; m_drops = 0;
        exp_q.delete();
    endtask

    // One bus cycle: drive at the falling edge, check, then advance the model
    // to what the next rising edge should do.
    task automatic cyc(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic rdy);
        bit          h;
        bit          pop;
        logic [31:0] ts;
        @(negedge clk);
        MemWrite = we; DataAdr = adr; WriteData = wd; out_ready = rdy;
        #1;
        h = (adr[31:4] == 28'h0000010);
        check("hit", {31'd0, hit}, {31'd0, h});
        check("ReadData", ReadData, model_rd(adr));
        check("out_valid", {31'd0, out_valid}, {31'd0, (msize > 0)});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("pass", {31'd0, pass}, {31'd0, m_pass});
        pop = rdy && (msize > 0);
`ifdef MAILBOX_TIMESTAMP_EN
        ts = 32'(edge_cnt);
`else
        ts = 32'd0;
`endif
        if (we && h) begin
            case (adr[3:2])
                2'd0: if (!m_done) begin
                    if (msize < DEPTH || pop) begin
                        exp_q.push_back({ts, wd});
                        msize++;
                    end else begin
                        if (m_drops < 65535) m_drops++;
                        m_ovf = 1;
                    end
                end
                2'd2: if (!m_done) begin
                    m_done = 1; m_code = wd; m_pass = (wd == 32'd7);
                end
                2'd3: m_drops = 0;
                default: ;
            endcase
        end
        if (pop) msize--;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        @(negedge clk);
        MemWrite = 1'b0; DataAdr = 32'h100; out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_count", ReadData, 32'd0);
        DataAdr = 32'h10C; #1;
        check("rst_drops", ReadData, 32'd0);
        model_clear();
        #3 reset = 1'b1;
    endtask

    // Stream monitor: samples between edges, compares each handed-over word.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL stream_extra: got word %h, expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[31:0]);
                    check("out_ts", out_ts, e[63:32]);
                end
            end
        end
    end

    initial begin
        logic [31:0] adr;
        logic [31:0] wd;
        int          sel;
        model_clear();
        #2;
        check("init_out_valid", {31'd0, out_valid}, 32'd0);
        check("init_done", {31'd0, done}, 32'd0);
        #5 reset = 1'b1;

        // Three words queued, then drained in order
        cyc(1'b1, 32'h100, 32'h11, 1'b0);
        cyc(1'b1, 32'h100, 32'h22, 1'b0);
        cyc(1'b1, 32'h100, 32'h33, 1'b0);
        cyc(1'b0, 32'h100, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h100, 32'h0, 1'b1);

        // Overflow: ten pushes into eight slots
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h100, 32'hA0 + 32'(i), 1'b0);
        cyc(1'b0, 32'h10C, 32'h0, 1'b0);
        cyc(1'b0, 32'h104, 32'h0, 1'b0);
        cyc(1'b1, 32'h10C, 32'h0, 1'b0);
        cyc(1'b0, 32'h10C, 32'h0, 1'b0);
        cyc(1'b0, 32'h104, 32'h0, 1'b0);
        // Full with simultaneous pop and push
        cyc(1'b1, 32'h100, 32'hBEEF, 1'b1);
        cyc(1'b0, 32'h100, 32'h0, 1'b0);
        cyc(1'b0, 32'h10C, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 32'h104, 32'h0, 1'b1);

        // Outside the window: no effect
        cyc(1'b1, 32'h200, 32'hDEAD, 1'b0);
        cyc(1'b1, 32'h208, 32'h7, 1'b0);
        cyc(1'b0, 32'h104, 32'h0, 1'b0);

        // DONE with the pass code, second code ignored
        cyc(1'b1, 32'h108, 32'd7, 1'b0);
        cyc(1'b1, 32'h108, 32'd5, 1'b0);
        cyc(1'b1, 32'h100, 32'h55, 1'b0);
        cyc(1'b0, 32'h108, 32'h0, 1'b0);
        cyc(1'b0, 32'h104, 32'h0, 1'b0);
        do_reset();
        cyc(1'b1, 32'h108, 32'd6, 1'b0);
        cyc(1'b0, 32'h104, 32'h0, 1'b0);
        do_reset();

        // Reset mid-run with three words queued and done set
        cyc(1'b1, 32'h100, 32'h1, 1'b0);
        cyc(1'b1, 32'h100, 32'h2, 1'b0);
        cyc(1'b1, 32'h100, 32'h3, 1'b0);
        cyc(1'b1, 32'h108, 32'd7, 1'b0);
        cyc(1'b0, 32'h100, 32'h0, 1'b0);
        do_reset();

        // Timestamp spacing: pushes three cycles apart
        for (int i = 0; i < 9; i++) cyc(1'b0, 32'h104, 32'h0, 1'b0);
        cyc(1'b1, 32'h100, 32'hC1, 1'b0);
        cyc(1'b0, 32'h104, 32'h0, 1'b0);
        cyc(1'b0, 32'h104, 32'h0, 1'b0);
        cyc(1'b1, 32'h100, 32'hC2, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h100, 32'h0, 1'b1);

        // Randomized traffic, several runs separated by resets
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 200; i++) begin
                sel = $urandom_range(0, 99);
                wd  = $urandom;
                if (sel < 45)      adr = 32'h100 | 32'($urandom_range(0, 3));
                else if (sel < 60) adr = 32'h104;
                else if (sel < 62) begin
                    adr = 32'h108;
                    if ($urandom_range(0, 1) == 0) wd = 32'd7;
                end
                else if (sel < 72) adr = 32'h10C;
                else if (sel < 85) adr = 32'h200 | 32'($urandom_range(0, 15));
                else               adr = $urandom;
                cyc(1'($urandom_range(0, 1)), adr, wd,
                    ($urandom_range(0, 3) < ((r % 2 == 0) ? 1 : 3)));
            end
        end

        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 32'h100, 32'h0, 1'b1);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
